// File: rtl/mby_igr_pb_pkg.sv
// Ingress packet-buffer shared types and sizing.
// Bank shell bundles and per-bank FIFO bookkeeping state.
package mby_igr_pb_pkg;

  localparam int PB_BANKS        = 4;
  localparam int PB_BANK_D       = 1024;
  localparam int PB_SHELL_DATA_W = 644;
  localparam int PB_RD_LAT       = 2;
  localparam int STARVE_MAX      = 4;

  localparam int PB_ADR_W    = $clog2(PB_BANK_D);
  localparam int PB_OCC_W    = $clog2(PB_BANK_D) + 1;
  localparam int PB_BANK_W   = $clog2(PB_BANKS);
  localparam int PB_STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int PB_QUIET_W  = $clog2(PB_RD_LAT + 2);

  typedef struct packed {
    logic                       rd_en;
    logic                       wr_en;
    logic [PB_ADR_W-1:0]        adr;
    logic [PB_SHELL_DATA_W-1:0] wr_data;
  } pb_shell_ctrl_wdata_t;

  typedef struct packed {
    logic                       rd_valid;
    logic [PB_SHELL_DATA_W-1:0] rd_data;
  } pb_shell_rdata_t;

  typedef struct packed {
    logic [PB_ADR_W-1:0]    wr_ptr;
    logic [PB_ADR_W-1:0]    rd_ptr;
    logic [PB_OCC_W-1:0]    occ;
    logic [PB_STARVE_W-1:0] starve;
  } pb_bank_state_t;

  function automatic logic [PB_ADR_W-1:0] pb_ptr_inc(
    input logic [PB_ADR_W-1:0] p
  );
    if (p == PB_ADR_W'(PB_BANK_D - 1))
      return '0;
    return p + PB_ADR_W'(1);
  endfunction

endpackage

// File: rtl/mby_igr_pb_bank_fifo_ctl.sv
// One bank's pointers, occupancy and write/read grant.
// Write wins a same-bank clash until the read has starved STARVE_MAX times.
module mby_igr_pb_bank_fifo_ctl
  import mby_igr_pb_pkg::*;
(
  input  logic                cclk,
  input  logic                rst,
  input  logic                wr_req,
  input  logic                rd_req,
  output logic                wr_gnt,
  output logic                rd_gnt,
  output logic [PB_ADR_W-1:0] wr_ptr,
  output logic [PB_ADR_W-1:0] rd_ptr,
  output logic [PB_OCC_W-1:0] occ,
  output logic                full,
  output logic                empty
);

  pb_bank_state_t st_q;
  pb_bank_state_t st_d;
  logic           full_q;
  logic           empty_q;
  logic           wr_elig;
  logic           rd_elig;
  logic           starved;

  always_comb begin
    wr_elig = wr_req && !full_q;
    rd_elig = rd_req && !empty_q;
    starved = st_q.starve == PB_STARVE_W'(STARVE_MAX);
    wr_gnt  = wr_elig && !(rd_elig && starved);
    rd_gnt  = rd_elig && !(wr_elig && !starved);
  end

  always_comb begin
    st_d = st_q;
    if (wr_gnt) begin
      st_d.wr_ptr = pb_ptr_inc(st_q.wr_ptr);
      st_d.occ    = st_q.occ + PB_OCC_W'(1);
    end
    if (rd_gnt) begin
      st_d.rd_ptr = pb_ptr_inc(st_q.rd_ptr);
      st_d.occ    = st_q.occ - PB_OCC_W'(1);
      st_d.starve = '0;
    end else if (wr_elig && rd_elig) begin
      // only reached when the read lost, so never past STARVE_MAX
      st_d.starve = st_q.starve + PB_STARVE_W'(1);
    end
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      st_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      full_q  <= st_d.occ == PB_OCC_W'(PB_BANK_D);
      empty_q <= st_d.occ == '0;
    end
  end

  assign wr_ptr = st_q.wr_ptr;
  assign rd_ptr = st_q.rd_ptr;
  assign occ    = st_q.occ;
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: rtl/mby_igr_pb_bank_sched.sv
// Ingress packet-buffer bank scheduler: write/read arbitration onto
// the bank shells and in-order return of read data.
module mby_igr_pb_bank_sched
  import mby_igr_pb_pkg::*;
(
  input  logic                                cclk,
  input  logic                                rst,
  input  logic                                i_wr_v,
  input  logic [PB_BANK_W-1:0]                i_wr_bank,
  input  logic [PB_SHELL_DATA_W-1:0]          i_wr_data,
  output logic                                o_wr_rdy,
  input  logic                                i_rd_v,
  input  logic [PB_BANK_W-1:0]                i_rd_bank,
  output logic                                o_rd_rdy,
  output pb_shell_ctrl_wdata_t [PB_BANKS-1:0] o_shell_ctrl,
  input  pb_shell_rdata_t [PB_BANKS-1:0]      i_shell_rdata,
  output logic                                o_rd_v,
  output logic [PB_BANK_W-1:0]                o_rd_bank,
  output logic [PB_SHELL_DATA_W-1:0]          o_rd_data,
  output logic [PB_BANKS-1:0][PB_OCC_W-1:0]   o_bank_occ,
  output logic [PB_BANKS-1:0]                 o_bank_full,
  output logic [PB_BANKS-1:0]                 o_bank_empty,
  output logic                                o_rd_err
);

  logic [PB_QUIET_W-1:0]      quiet_q;
  logic                       quiet;
  logic [PB_BANKS-1:0]        wr_req;
  logic [PB_BANKS-1:0]        rd_req;
  logic [PB_BANKS-1:0]        wr_gnt;
  logic [PB_BANKS-1:0]        rd_gnt;
  logic [PB_ADR_W-1:0]        wr_ptr [PB_BANKS];
  logic [PB_ADR_W-1:0]        rd_ptr [PB_BANKS];
  pb_shell_ctrl_wdata_t [PB_BANKS-1:0] ctrl_d;
  logic [PB_BANKS-1:0]        vld;
  logic                       multi;
  logic [PB_BANK_W-1:0]       sel_bank;
  logic [PB_SHELL_DATA_W-1:0] sel_data;

  // quiet window drops returns from reads issued before reset
  always_ff @(posedge cclk) begin
    if (rst)
      quiet_q <= PB_QUIET_W'(PB_RD_LAT + 1);
    else if (quiet)
      quiet_q <= quiet_q - PB_QUIET_W'(1);
  end

  assign quiet = quiet_q != '0;

  for (genvar b = 0; b < PB_BANKS; b++) begin : g_bank
    assign wr_req[b] = i_wr_v &&
                       (i_wr_bank == PB_BANK_W'(b));
    assign rd_req[b] = i_rd_v && !quiet &&
                       (i_rd_bank == PB_BANK_W'(b));

    mby_igr_pb_bank_fifo_ctl u_ctl (
      .cclk   (cclk),
      .rst    (rst),
      .wr_req (wr_req[b]),
      .rd_req (rd_req[b]),
      .wr_gnt (wr_gnt[b]),
      .rd_gnt (rd_gnt[b]),
      .wr_ptr (wr_ptr[b]),
      .rd_ptr (rd_ptr[b]),
      .occ    (o_bank_occ[b]),
      .full   (o_bank_full[b]),
      .empty  (o_bank_empty[b])
    );
  end

  assign o_wr_rdy = wr_gnt[i_wr_bank];
  assign o_rd_rdy = rd_gnt[i_rd_bank];

  always_comb begin
    ctrl_d = '0;
    for (int b = 0; b < PB_BANKS; b++) begin
      ctrl_d[b].wr_en = wr_gnt[b];
      ctrl_d[b].rd_en = rd_gnt[b];
      if (wr_gnt[b]) begin
        ctrl_d[b].adr     = wr_ptr[b];
        ctrl_d[b].wr_data = i_wr_data;
      end else if (rd_gnt[b]) begin
        ctrl_d[b].adr = rd_ptr[b];
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (rst)
      o_shell_ctrl <= '0;
    else
      o_shell_ctrl <= ctrl_d;
  end

  // lowest-index valid bank wins if the shells ever collide
  always_comb begin
    vld      = '0;
    sel_bank = '0;
    sel_data = '0;
    for (int b = 0; b < PB_BANKS; b++)
      vld[b] = i_shell_rdata[b].rd_valid && !quiet;
    for (int b = PB_BANKS - 1; b >= 0; b--) begin
      if (vld[b]) begin
        sel_bank = PB_BANK_W'(b);
        sel_data = i_shell_rdata[b].rd_data;
      end
    end
    multi = |(vld & (vld - PB_BANKS'(1)));
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      o_rd_v    <= 1'b0;
      o_rd_bank <= '0;
      o_rd_data <= '0;
      o_rd_err  <= 1'b0;
    end else begin
      o_rd_v    <= |vld;
      o_rd_bank <= sel_bank;
      o_rd_data <= sel_data;
      o_rd_err  <= o_rd_err | multi;
    end
  end

endmodule

// File: tb/tb_mby_igr_pb_bank_sched.sv
// Randomized bench for the PB bank scheduler with shell models
// and a queue-based reference of bank contents and return order.
module tb_mby_igr_pb_bank_sched;
  import mby_igr_pb_pkg::*;

  localparam int W   = PB_SHELL_DATA_W;
  localparam int LAT = PB_RD_LAT + 2;

  typedef logic [W-1:0] data_t;

  typedef struct {
    int    due;
    int    bank;
    data_t data;
  } ret_t;

  logic                                cclk = 1'b0;
  logic                                rst  = 1'b1;
  logic                                i_wr_v = 1'b0;
  logic [PB_BANK_W-1:0]                i_wr_bank = '0;
  data_t                               i_wr_data = '0;
  logic                                o_wr_rdy;
  logic                                i_rd_v = 1'b0;
  logic [PB_BANK_W-1:0]                i_rd_bank = '0;
  logic                                o_rd_rdy;
  pb_shell_ctrl_wdata_t [PB_BANKS-1:0] o_shell_ctrl;
  pb_shell_rdata_t [PB_BANKS-1:0]      i_shell_rdata;
  logic                                o_rd_v;
  logic [PB_BANK_W-1:0]                o_rd_bank;
  data_t                               o_rd_data;
  logic [PB_BANKS-1:0][PB_OCC_W-1:0]   o_bank_occ;
  logic [PB_BANKS-1:0]                 o_bank_full;
  logic [PB_BANKS-1:0]                 o_bank_empty;
  logic                                o_rd_err;

  always #5 cclk = ~cclk;

  mby_igr_pb_bank_sched dut (
    .cclk          (cclk),
    .rst           (rst),
    .i_wr_v        (i_wr_v),
    .i_wr_bank     (i_wr_bank),
    .i_wr_data     (i_wr_data),
    .o_wr_rdy      (o_wr_rdy),
    .i_rd_v        (i_rd_v),
    .i_rd_bank     (i_rd_bank),
    .o_rd_rdy      (o_rd_rdy),
    .o_shell_ctrl  (o_shell_ctrl),
    .i_shell_rdata (i_shell_rdata),
    .o_rd_v        (o_rd_v),
    .o_rd_bank     (o_rd_bank),
    .o_rd_data     (o_rd_data),
    .o_bank_occ    (o_bank_occ),
    .o_bank_full   (o_bank_full),
    .o_bank_empty  (o_bank_empty),
    .o_rd_err      (o_rd_err)
  );

  // single-port shell models with fixed read latency
  data_t smem [PB_BANKS][PB_BANK_D];
  logic  pv   [PB_BANKS][PB_RD_LAT];
  data_t pd   [PB_BANKS][PB_RD_LAT];
  logic [PB_BANKS-1:0] force_v = '0;
  data_t force_d [PB_BANKS];

  initial begin
    for (int b = 0; b < PB_BANKS; b++) begin
      force_d[b] = '0;
      for (int s = 0; s < PB_RD_LAT; s++) begin
        pv[b][s] = 1'b0;
        pd[b][s] = '0;
      end
    end
  end

  always @(posedge cclk) begin
    for (int b = 0; b < PB_BANKS; b++) begin
      if (o_shell_ctrl[b].wr_en)
        smem[b][o_shell_ctrl[b].adr] <= o_shell_ctrl[b].wr_data;
      pv[b][0] <= o_shell_ctrl[b].rd_en;
      pd[b][0] <= smem[b][o_shell_ctrl[b].adr];
      for (int s = 1; s < PB_RD_LAT; s++) begin
        pv[b][s] <= pv[b][s-1];
        pd[b][s] <= pd[b][s-1];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < PB_BANKS; b++) begin
      i_shell_rdata[b].rd_valid = pv[b][PB_RD_LAT-1] | force_v[b];
      if (force_v[b])
        i_shell_rdata[b].rd_data = force_d[b];
      else if (pv[b][PB_RD_LAT-1])
        i_shell_rdata[b].rd_data = pd[b][PB_RD_LAT-1];
      else
        i_shell_rdata[b].rd_data = '0;
    end
  end

  // reference model
  data_t mq [PB_BANKS][PB_BANK_D];
  int    mh [PB_BANKS];
  int    mn [PB_BANKS];
  int    wcnt [PB_BANKS];
  int    rcnt [PB_BANKS];
  int    stv  [PB_BANKS];
  logic  exp_wen [PB_BANKS];
  logic  exp_ren [PB_BANKS];
  int    exp_adr [PB_BANKS];
  data_t exp_wd  [PB_BANKS];
  ret_t  rq [$];
  int    quiet;
  int    cyc;
  int    err_at;
  int    wr_acc;
  int    rd_acc;
  int    nchk;
  int    nfail;

  task automatic chk(input string tag, input data_t got, input data_t exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic data_t rnd_data();
    data_t d = '0;
    for (int i = 0; i < (W + 31) / 32; i++)
      d = (d << 32) | data_t'($urandom);
    return d;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < PB_BANKS; b++) begin
      mh[b] = 0; mn[b] = 0;
      wcnt[b] = 0; rcnt[b] = 0; stv[b] = 0;
      exp_wen[b] = 1'b0; exp_ren[b] = 1'b0;
      exp_adr[b] = 0; exp_wd[b] = '0;
    end
    rq.delete();
    err_at = -1;
    quiet  = PB_RD_LAT + 1;
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    i_wr_v = 1'b0;
    i_rd_v = 1'b0;
    repeat (n) @(negedge cclk);
    for (int b = 0; b < PB_BANKS; b++) begin
      chk("rst_occ", W'(o_bank_occ[b]), '0);
      chk("rst_full", W'(o_bank_full[b]), '0);
      chk("rst_empty", W'(o_bank_empty[b]), W'(1));
      chk("rst_ctrl", W'({o_shell_ctrl[b].rd_en,
                          o_shell_ctrl[b].wr_en,
                          o_shell_ctrl[b].adr}), '0);
      chk("rst_wdata", o_shell_ctrl[b].wr_data, '0);
    end
    chk("rst_rd_v", W'(o_rd_v), '0);
    chk("rst_rd_bank", W'(o_rd_bank), '0);
    chk("rst_rd_data", o_rd_data, '0);
    chk("rst_rd_err", W'(o_rd_err), '0);
    model_clear();
    rst = 1'b0;
  endtask

  task automatic step(input logic wv, input int wb, input data_t wd,
                      input logic rv, input int rb);
    bit    wok;
    bit    rok;
    ret_t  r;
    i_wr_v    = wv;
    i_wr_bank = PB_BANK_W'(wb);
    i_wr_data = wd;
    i_rd_v    = rv;
    i_rd_bank = PB_BANK_W'(rb);
    #1;
    for (int b = 0; b < PB_BANKS; b++) begin
      chk("occ", W'(o_bank_occ[b]), W'(mn[b]));
      chk("full", W'(o_bank_full[b]), W'(mn[b] == PB_BANK_D));
      chk("empty", W'(o_bank_empty[b]), W'(mn[b] == 0));
      chk("wr_en", W'(o_shell_ctrl[b].wr_en), W'(exp_wen[b]));
      chk("rd_en", W'(o_shell_ctrl[b].rd_en), W'(exp_ren[b]));
      if (exp_wen[b] || exp_ren[b])
        chk("adr", W'(o_shell_ctrl[b].adr), W'(exp_adr[b]));
      if (exp_wen[b])
        chk("wr_data", o_shell_ctrl[b].wr_data, exp_wd[b]);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("rd_v", W'(o_rd_v), W'(1));
      chk("rd_bank", W'(o_rd_bank), W'(rq[0].bank));
      chk("rd_data", o_rd_data, rq[0].data);
      void'(rq.pop_front());
    end else begin
      chk("rd_v_idle", W'(o_rd_v), '0);
    end
    chk("rd_err", W'(o_rd_err), W'(err_at >= 0 && cyc >= err_at));

    wok = wv && mn[wb] < PB_BANK_D;
    rok = rv && mn[rb] > 0 && quiet == 0;
    if (wok && rok && wb == rb) begin
      if (stv[wb] == STARVE_MAX) begin
        wok = 1'b0;
      end else begin
        rok = 1'b0;
        stv[wb]++;
      end
    end
    if (rok) stv[rb] = 0;
    chk("wr_rdy", W'(o_wr_rdy), W'(wok));
    chk("rd_rdy", W'(o_rd_rdy), W'(rok));

    for (int b = 0; b < PB_BANKS; b++) begin
      exp_wen[b] = 1'b0;
      exp_ren[b] = 1'b0;
    end
    if (wok) begin
      mq[wb][(mh[wb] + mn[wb]) % PB_BANK_D] = wd;
      mn[wb]++;
      exp_wen[wb] = 1'b1;
      exp_adr[wb] = wcnt[wb] % PB_BANK_D;
      exp_wd[wb]  = wd;
      wcnt[wb]++;
      wr_acc++;
    end
    if (rok) begin
      r.due  = cyc + LAT;
      r.bank = rb;
      r.data = mq[rb][mh[rb]];
      rq.push_back(r);
      mh[rb] = (mh[rb] + 1) % PB_BANK_D;
      mn[rb]--;
      exp_ren[rb] = 1'b1;
      exp_adr[rb] = rcnt[rb] % PB_BANK_D;
      rcnt[rb]++;
      rd_acc++;
    end
    if (quiet > 0) quiet--;
    @(negedge cclk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, '0, 1'b0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_t a5;
    int    r0;
    nchk = 0; nfail = 0; cyc = 0;
    wr_acc = 0; rd_acc = 0;
    model_clear();
    do_reset(2);

    // fill bank 2, overflow attempt, then pointer wrap
    for (int i = 0; i < PB_BANK_D; i++)
      step(1'b1, 2, rnd_data(), 1'b0, 0);
    chk("full2", W'(o_bank_full[2]), W'(1));
    chk("occ2", W'(o_bank_occ[2]), W'(PB_BANK_D));
    step(1'b1, 2, rnd_data(), 1'b0, 0);
    step(1'b0, 0, '0, 1'b1, 2);
    step(1'b1, 2, rnd_data(), 1'b0, 0);
    idle(6);

    // single write/read latency on bank 0
    a5 = '0;
    for (int i = 0; i < W; i += 8)
      a5 = a5 | (data_t'(8'hA5) << i);
    step(1'b1, 0, a5, 1'b0, 0);
    step(1'b0, 0, '0, 1'b1, 0);
    idle(6);

    // same-bank contention on bank 1
    repeat (3) step(1'b1, 1, rnd_data(), 1'b0, 0);
    r0 = rd_acc;
    repeat (25) step(1'b1, 1, rnd_data(), 1'b1, 1);
    chk("starve_reads", W'(rd_acc - r0), W'(5));
    idle(6);

    // different banks accepted together
    repeat (2) step(1'b1, 3, rnd_data(), 1'b0, 0);
    r0 = wr_acc + rd_acc;
    step(1'b1, 0, rnd_data(), 1'b1, 3);
    chk("dual_accept", W'(wr_acc + rd_acc - r0), W'(2));
    idle(2);

    // reset right after a read accept
    step(1'b0, 0, '0, 1'b1, 3);
    do_reset(2);
    step(1'b1, 0, rnd_data(), 1'b1, 0);
    step(1'b0, 0, '0, 1'b1, 0);
    step(1'b0, 0, '0, 1'b1, 0);
    step(1'b0, 0, '0, 1'b1, 0);
    idle(6);

    // colliding shell returns
    force_v    = 4'b0110;
    force_d[1] = rnd_data();
    force_d[2] = rnd_data();
    begin
      ret_t r;
      r.due  = cyc + 1;
      r.bank = 1;
      r.data = force_d[1];
      rq.push_back(r);
    end
    err_at = cyc + 1;
    step(1'b0, 0, '0, 1'b0, 0);
    force_v = '0;
    idle(5);
    do_reset(1);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, PB_BANKS - 1),
           rnd_data(),
           $urandom_range(0, 9) < 5, $urandom_range(0, PB_BANKS - 1));
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
